// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier narrowing path.
// Result-width defaults, statistics counter width and FIFO state encoding.
package mul_pkg;

   localparam int SIZE_NARROW = 8;
   localparam int SIZE_WIDE   = 16;
   localparam int CNT_W       = 16;

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      FULL
   } fifo_state_t;

   // Increment that parks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/mul_skid2.sv
// Generic 2-entry valid/ready buffer; head entry drives the output directly.
// in_ready depends only on occupancy, never on out_ready.
module mul_skid2
   import mul_pkg::*;
#(
   parameter int W = SIZE_WIDE + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   fifo_state_t  state;
   logic [W-1:0] head;
   logic [W-1:0] tail;
   logic         acc;
   logic         pop;

   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign out_data  = head;
   assign acc       = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= EMPTY;
         head  <= '0;
         tail  <= '0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (acc) begin
                  head  <= in_data;
                  state <= ONE;
               end
            end
            ONE: begin
               if (acc && pop) begin
                  head <= in_data;
               end else if (acc) begin
                  tail  <= in_data;
                  state <= FULL;
               end else if (pop) begin
                  state <= EMPTY;
               end
            end
            FULL: begin
               // No accept is possible here, so a pop just promotes the tail.
               if (pop) begin
                  head  <= tail;
                  state <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/mul_narrow.sv
// Narrows a 2*SIZE signed product to SIZE bits with overflow statistics.
// Define MUL_NARROW_SAT_EN to saturate overflowing results instead of wrapping.
module mul_narrow
   import mul_pkg::*;
#(
   parameter int SIZE = SIZE_WIDE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2*SIZE-1:0] in_product,
   input  logic              in_overflow,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SIZE-1:0]   out_data,
   output logic              out_ovf,
   input  logic              clr,
   output logic [CNT_W-1:0]  ovf_count,
   output logic              ovf_sticky
);

   logic [SIZE:0]   hi;
   logic            fit;
   logic            ovf;
   logic [SIZE-1:0] narrow;
   logic            acc;
   logic            acc_ovf;

   // The product fits when every bit from the result MSB upward is a sign copy.
   assign hi  = in_product[2*SIZE-1:SIZE-1];
   assign fit = (&hi) | ~(|hi);
   assign ovf = ~fit | in_overflow;

`ifdef MUL_NARROW_SAT_EN
   localparam logic [SIZE-1:0] MAX_POS = {1'b0, {(SIZE-1){1'b1}}};
   localparam logic [SIZE-1:0] MIN_NEG = {1'b1, {(SIZE-1){1'b0}}};

   assign narrow = !ovf ? in_product[SIZE-1:0]
                 : (in_product[2*SIZE-1] ? MIN_NEG : MAX_POS);
`else
   assign narrow = in_product[SIZE-1:0];
`endif

   mul_skid2 #(
      .W (SIZE + 1)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({ovf, narrow}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  ({out_ovf, out_data})
   );

   assign acc     = in_valid && in_ready;
   assign acc_ovf = acc && ovf;

   // A clear that coincides with an overflow accept restarts the count at one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_count  <= '0;
         ovf_sticky <= 1'b0;
      end else if (clr) begin
         ovf_count  <= acc_ovf ? CNT_W'(1) : '0;
         ovf_sticky <= acc_ovf;
      end else if (acc_ovf) begin
         ovf_count  <= sat_inc(ovf_count);
         ovf_sticky <= 1'b1;
      end
   end

endmodule
